// File: rtl/sound_pulse_channel_gen.sv
// Square-wave sound channel: duty-cycle pulse with volume envelope, length
// counter and optional frequency sweep. Channel 1 uses SWEEP_EN=1, channel 2
// uses SWEEP_EN=0. Sample and active flag are registered (one cycle latency).
module sound_pulse_channel_gen #(
  parameter int FREQ_WIDTH = 11,
  parameter int LEN_WIDTH  = 6,
  parameter int OUT_WIDTH  = 5,
  parameter bit SWEEP_EN   = 1'b1
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iOsc64,
  input  logic                 iOsc128,
  input  logic                 iOsc256,
  input  logic                 iOsc262k,
  input  logic [7:0]           iNR10,
  input  logic [7:0]           iNR11,
  input  logic [7:0]           iNR12,
  input  logic [7:0]           iNR13,
  input  logic [7:0]           iNR14,
  input  logic                 iTrigger,
  output logic [OUT_WIDTH-1:0] oOut,
  output logic                 oOnFlag
);

  // Period counter spans 1..2^FREQ_WIDTH, length counter 1..2^LEN_WIDTH.
  localparam int PW = FREQ_WIDTH + 1;
  localparam int LW = LEN_WIDTH + 1;
  localparam logic [PW-1:0] PER_FULL = {1'b1, {FREQ_WIDTH{1'b0}}};
  localparam logic [LW-1:0] LEN_FULL = {1'b1, {LEN_WIDTH{1'b0}}};

  // Register fields
  logic [FREQ_WIDTH-1:0] freq_live;
  logic                  dac_on;
  logic [2:0]            env_per;
  logic                  env_up;
  logic [2:0]            sw_per;
  logic                  sw_neg;
  logic [2:0]            sw_shift;
  logic                  len_en;
  logic [1:0]            duty;

  assign freq_live = {iNR14[FREQ_WIDTH-9:0], iNR13};
  assign dac_on    = |iNR12[7:3];
  assign env_per   = iNR12[2:0];
  assign env_up    = iNR12[3];
  assign sw_per    = iNR10[6:4];
  assign sw_neg    = iNR10[3];
  assign sw_shift  = iNR10[2:0];
  assign len_en    = iNR14[6];
  assign duty      = iNR11[7:6];

  // Fields not used by every configuration (sweep inputs when SWEEP_EN=0,
  // spare register bits) are folded here so they are consciously ignored.
  logic unused_ok;
  assign unused_ok = ^{iNR10, iNR11, iNR12, iNR14, iOsc128};

  // State
  logic [3:0]            osc_q, osc_d;
  logic                  enable_q, enable_d;
  logic [3:0]            volume_q, volume_d;
  logic [2:0]            env_cnt_q, env_cnt_d;
  logic [LW-1:0]         len_cnt_q, len_cnt_d;
  logic [PW-1:0]         per_cnt_q, per_cnt_d;
  logic [2:0]            step_q, step_d;
  logic [FREQ_WIDTH-1:0] shadow_q, shadow_d;
  logic [2:0]            sweep_cnt_q, sweep_cnt_d;
  logic [OUT_WIDTH-1:0]  out_q, out_d;
  logic                  on_q, on_d;

  // Rising-edge ticks of the frame oscillators, one clock wide
  logic tick_64, tick_128, tick_256, tick_262k;
  assign osc_d     = {iOsc262k, iOsc256, iOsc128, iOsc64};
  assign tick_64   = iOsc64   & ~osc_q[0];
  assign tick_128  = iOsc128  & ~osc_q[1];
  assign tick_256  = iOsc256  & ~osc_q[2];
  assign tick_262k = iOsc262k & ~osc_q[3];

  // shadow +/- (shadow >> shift) with one guard bit; guard set = out of range
  function automatic logic [PW-1:0] sweep_calc(input logic [FREQ_WIDTH-1:0] f,
                                               input logic neg,
                                               input logic [2:0] sh);
    logic [PW-1:0] ext;
    logic [PW-1:0] delta;
    ext   = {1'b0, f};
    delta = ext >> sh;
    return neg ? (ext - delta) : (ext + delta);
  endfunction

  logic [PW-1:0]         sweep_new, sweep_trig;
  logic [FREQ_WIDTH-1:0] per_freq;
  logic [PW-1:0]         per_reload;
  logic [LW-1:0]         len_load;
  logic [7:0]            duty_pat;
  logic                  duty_bit;

  assign sweep_new  = sweep_calc(shadow_q, sw_neg, sw_shift);
  assign sweep_trig = sweep_calc(freq_live, sw_neg, sw_shift);
  assign per_freq   = SWEEP_EN ? shadow_q : freq_live;
  assign per_reload = PER_FULL - {1'b0, per_freq};
  assign len_load   = LEN_FULL - {1'b0, iNR11[LEN_WIDTH-1:0]};

  // Duty waveform, MSB is step 0
  always_comb begin
    duty_pat = 8'b0000_0001;
    case (duty)
      2'b00:   duty_pat = 8'b0000_0001;
      2'b01:   duty_pat = 8'b1000_0001;
      2'b10:   duty_pat = 8'b1000_0111;
      default: duty_pat = 8'b0111_1110;
    endcase
  end
  assign duty_bit = duty_pat[~step_q];

  // Next-state: timer, envelope, length, sweep; trigger overrides ticks,
  // DAC off overrides everything for the enable.
  always_comb begin
    enable_d    = enable_q;
    volume_d    = volume_q;
    env_cnt_d   = env_cnt_q;
    len_cnt_d   = len_cnt_q;
    per_cnt_d   = per_cnt_q;
    step_d      = step_q;
    shadow_d    = shadow_q;
    sweep_cnt_d = sweep_cnt_q;

    if (tick_262k) begin
      if (per_cnt_q <= PW'(1)) begin
        per_cnt_d = per_reload;
        step_d    = step_q + 3'd1;
      end else begin
        per_cnt_d = per_cnt_q - PW'(1);
      end
    end

    if (tick_64 && env_per != 3'd0) begin
      if (env_cnt_q <= 3'd1) begin
        env_cnt_d = env_per;
        if (env_up && volume_q != 4'd15)       volume_d = volume_q + 4'd1;
        else if (!env_up && volume_q != 4'd0)  volume_d = volume_q - 4'd1;
      end else begin
        env_cnt_d = env_cnt_q - 3'd1;
      end
    end

    if (tick_256 && len_en && len_cnt_q != '0) begin
      len_cnt_d = len_cnt_q - LW'(1);
      if (len_cnt_q == LW'(1)) enable_d = 1'b0;
    end

    if (SWEEP_EN && tick_128 && sw_per != 3'd0) begin
      if (sweep_cnt_q <= 3'd1) begin
        sweep_cnt_d = sw_per;
        if (sweep_new[FREQ_WIDTH])  enable_d = 1'b0;
        else if (sw_shift != 3'd0)  shadow_d = sweep_new[FREQ_WIDTH-1:0];
      end else begin
        sweep_cnt_d = sweep_cnt_q - 3'd1;
      end
    end

    if (iTrigger) begin
      enable_d  = dac_on;
      len_cnt_d = (len_load == '0) ? LEN_FULL : len_load;
      volume_d  = iNR12[7:4];
      env_cnt_d = env_per;
      step_d    = 3'd0;
      per_cnt_d = PER_FULL - {1'b0, freq_live};
      if (SWEEP_EN) begin
        shadow_d    = freq_live;
        sweep_cnt_d = sw_per;
        if (sw_shift != 3'd0 && sweep_trig[FREQ_WIDTH]) enable_d = 1'b0;
      end
    end

    if (!dac_on) enable_d = 1'b0;
  end

  // Output sample from current state
  always_comb begin
    out_d = '0;
    if (enable_q && duty_bit) out_d = {{(OUT_WIDTH-4){1'b0}}, volume_q};
    on_d = enable_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      osc_q       <= '0;
      enable_q    <= 1'b0;
      volume_q    <= '0;
      env_cnt_q   <= '0;
      len_cnt_q   <= '0;
      per_cnt_q   <= '0;
      step_q      <= '0;
      shadow_q    <= '0;
      sweep_cnt_q <= '0;
      out_q       <= '0;
      on_q        <= 1'b0;
    end else begin
      osc_q       <= osc_d;
      enable_q    <= enable_d;
      volume_q    <= volume_d;
      env_cnt_q   <= env_cnt_d;
      len_cnt_q   <= len_cnt_d;
      per_cnt_q   <= per_cnt_d;
      step_q      <= step_d;
      shadow_q    <= shadow_d;
      sweep_cnt_q <= sweep_cnt_d;
      out_q       <= out_d;
      on_q        <= on_d;
    end
  end

  assign oOut    = out_q;
  assign oOnFlag = on_q;

endmodule
